// File: rtl/riscv_base_defines.sv
// rtl/riscv_base_defines.sv - shared M-extension constants, requester ids and tag type
package riscv_base_defines;

  localparam logic [31:0] INST_MUL         = 32'h02000033;
  localparam logic [31:0] INST_MUL_MASK    = 32'hfe00707f;
  localparam logic [31:0] INST_MULH        = 32'h02001033;
  localparam logic [31:0] INST_MULH_MASK   = 32'hfe00707f;
  localparam logic [31:0] INST_MULHSU      = 32'h02002033;
  localparam logic [31:0] INST_MULHSU_MASK = 32'hfe00707f;
  localparam logic [31:0] INST_MULHU       = 32'h02003033;
  localparam logic [31:0] INST_MULHU_MASK  = 32'hfe00707f;

  localparam int MUL_LATENCY_DEFAULT = 2;

  localparam logic REQ_ID_INT  = 1'b0;
  localparam logic REQ_ID_LANE = 1'b1;

  typedef struct packed {
    logic       valid;
    logic       id;
    logic [4:0] rd;
    logic       err;
  } mul_tag_t;

  function automatic logic is_mul_op(input logic [31:0] op);
    return ((op & INST_MUL_MASK) == INST_MUL) ||
           ((op & INST_MULH_MASK) == INST_MULH) ||
           ((op & INST_MULHSU_MASK) == INST_MULHSU) ||
           ((op & INST_MULHU_MASK) == INST_MULHU);
  endfunction

endpackage

// File: rtl/riscv_base_mul_rr_arbiter.sv
// rtl/riscv_base_mul_rr_arbiter.sv - two-way round-robin arbiter with last-grant register
module riscv_base_mul_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  // 1 means requester 1 won the most recent accepted handshake
  logic last_q;

  // On a tie, favour the requester that did not win last time
  always_comb begin
    grant_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_q)) begin
      grant_o = 2'b01;
    end else if (req_i[1]) begin
      grant_o = 2'b10;
    end
  end

  // Pointer moves only when a grant is actually taken
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= grant_o[1];
    end
  end

endmodule

// File: rtl/riscv_base_mul_issue_ctrl.sv
// rtl/riscv_base_mul_issue_ctrl.sv - two-requester issue controller for the shared multiplier
module riscv_base_mul_issue_ctrl
  import riscv_base_defines::*;
#(
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
  parameter int ID_W        = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [31:0]     req0_opcode_i,
  input  logic [4:0]      req0_rd_idx_i,
  input  logic [31:0]     req0_ra_operand_i,
  input  logic [31:0]     req0_rb_operand_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [31:0]     req1_opcode_i,
  input  logic [4:0]      req1_rd_idx_i,
  input  logic [31:0]     req1_ra_operand_i,
  input  logic [31:0]     req1_rb_operand_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            mul_valid_o,
  output logic [31:0]     mul_opcode_o,
  output logic [4:0]      mul_rd_idx_o,
  output logic [31:0]     mul_ra_operand_o,
  output logic [31:0]     mul_rb_operand_o,
  output logic            mul_hold_o,
  input  logic [31:0]     mul_result_i,
  output logic            wb_valid_o,
  output logic [ID_W-1:0] wb_id_o,
  output logic [4:0]      wb_rd_idx_o,
  output logic [31:0]     wb_value_o,
  output logic            wb_err_o,
  output logic            busy_o
);

  logic [1:0]  grant;
  logic        accept;
  logic        sel_id;
  logic [31:0] sel_opcode;
  logic [4:0]  sel_rd;
  logic [31:0] sel_ra;
  logic [31:0] sel_rb;

  logic        iss_valid;
  logic        iss_id;
  logic        iss_err;
  logic [31:0] iss_opcode;
  logic [4:0]  iss_rd;
  logic [31:0] iss_ra;
  logic [31:0] iss_rb;

  // tags[k] follows the multiplier stage k edges after it sampled the op;
  // wb_q lines up with the cycle in which mul_result_i holds that op's value
  mul_tag_t tags [MUL_LATENCY];
  mul_tag_t wb_q;

  riscv_base_mul_rr_arbiter u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    ({req1_valid_i, req0_valid_i}),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign req0_ready_o = grant[0] & ~hold_i & ~flush_i & rst_i;
  assign req1_ready_o = grant[1] & ~hold_i & ~flush_i & rst_i;
  assign accept       = (req0_ready_o & req0_valid_i) | (req1_ready_o & req1_valid_i);

  // Steer the granted requester's fields toward the issue register
  always_comb begin
    sel_id     = grant[1] ? REQ_ID_LANE : REQ_ID_INT;
    sel_opcode = grant[1] ? req1_opcode_i     : req0_opcode_i;
    sel_rd     = grant[1] ? req1_rd_idx_i     : req0_rd_idx_i;
    sel_ra     = grant[1] ? req1_ra_operand_i : req0_ra_operand_i;
    sel_rb     = grant[1] ? req1_rb_operand_i : req0_rb_operand_i;
  end

  // Issue register: loads on handshake, empties after one unstalled edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      iss_valid  <= 1'b0;
      iss_id     <= 1'b0;
      iss_err    <= 1'b0;
      iss_opcode <= '0;
      iss_rd     <= '0;
      iss_ra     <= '0;
      iss_rb     <= '0;
    end else if (flush_i) begin
      iss_valid <= 1'b0;
    end else if (!hold_i) begin
      iss_valid <= accept;
      if (accept) begin
        iss_id     <= sel_id;
        iss_err    <= ~is_mul_op(sel_opcode);
        iss_opcode <= sel_opcode;
        iss_rd     <= sel_rd;
        iss_ra     <= sel_ra;
        iss_rb     <= sel_rb;
      end
    end
  end

  // Tag pipe shadows the multiplier; flush drops valids, hold freezes everything
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < MUL_LATENCY; k++) begin
        tags[k] <= '0;
      end
      wb_q <= '0;
    end else if (flush_i) begin
      for (int k = 0; k < MUL_LATENCY; k++) begin
        tags[k].valid <= 1'b0;
      end
      wb_q.valid <= 1'b0;
    end else if (!hold_i) begin
      tags[0] <= '{iss_valid, iss_id, iss_rd, iss_err};
      for (int k = 1; k < MUL_LATENCY; k++) begin
        tags[k] <= tags[k-1];
      end
      wb_q <= tags[MUL_LATENCY-1];
    end
  end

  // Anything still owed a writeback keeps the block busy
  always_comb begin
    busy_o = iss_valid | wb_q.valid;
    for (int k = 0; k < MUL_LATENCY; k++) begin
      busy_o = busy_o | tags[k].valid;
    end
  end

  assign mul_valid_o      = iss_valid & ~iss_err;
  assign mul_opcode_o     = iss_opcode;
  assign mul_rd_idx_o     = iss_rd;
  assign mul_ra_operand_o = iss_ra;
  assign mul_rb_operand_o = iss_rb;
  assign mul_hold_o       = hold_i & rst_i;

  // During hold the multiplier output is frozen too, so value/err stay put
  assign wb_valid_o  = wb_q.valid & ~hold_i;
  assign wb_id_o     = ID_W'(wb_q.id);
  assign wb_rd_idx_o = wb_q.rd;
  assign wb_err_o    = wb_q.valid & wb_q.err;
  assign wb_value_o  = (wb_q.valid & ~wb_q.err) ? mul_result_i : 32'h0;

endmodule

// File: doc/riscv_base_mul_issue_ctrl.md
Name: riscv_base_mul_issue_ctrl

Overview:
Two-requester issue controller and scheduler for the shared pipelined riscv_base_multiplier. It round-robin arbitrates MUL/MULH/MULHSU/MULHU requests and drives the multiplier opcode/operand/hold inputs from an issue register. It tracks every in-flight operation through a latency-matched tag pipe and returns each result to its owner with rd index. It sits between the execute-stage requesters (integer pipe, secondary lane) and writeback.

Parameters:
MUL_LATENCY, 2, edges from the multiplier sampling a valid opcode to its writeback_value_o holding that result; legal range 1..4.
ID_W, 1, requester id width; fixed 1 for two requesters.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  one clock; reset is asynchronous and active-low
req0_valid_i  in  1  requester 0 has an operation
req0_ready_o  out  1  requester 0 accepted this cycle
req0_opcode_i  in  32  instruction word
req0_rd_idx_i  in  5  destination register
req0_ra_operand_i  in  32  rs1 value
req0_rb_operand_i  in  32  rs2 value
req1_valid_i, req1_ready_o, req1_opcode_i, req1_rd_idx_i, req1_ra_operand_i, req1_rb_operand_i: same widths and meanings as req0_*, for requester 1
hold_i  in  1  pipeline stall, freezes controller and multiplier
flush_i  in  1  discard all accepted, not-yet-written-back operations
mul_valid_o  out  1  to multiplier opcode_valid_i
mul_opcode_o  out  32  to opcode_opcode_i
mul_rd_idx_o  out  5  to opcode_rd_idx_i
mul_ra_operand_o  out  32  to opcode_ra_operand_i
mul_rb_operand_o  out  32  to opcode_rb_operand_i
mul_hold_o  out  1  to multiplier hold_i
mul_result_i  in  32  from multiplier writeback_value_o
wb_valid_o  out  1  result valid this cycle
wb_id_o  out  1  owning requester
wb_rd_idx_o  out  5  destination register
wb_value_o  out  32  result; 0 when wb_err_o=1
wb_err_o  out  1  op was not an M-extension multiply
busy_o  out  1  any op in issue register or tag pipe

Behaviour:
- Reset (rst_i=0, async): all valid bits 0; rr pointer set so req0 wins the first tie; every output 0 (mul_hold_o 0).
- Arbitration: only one request valid -> grant it. Both valid -> grant the requester not granted last; pointer updates only on an accepted handshake.
- reqX_ready_o = grantX & ~hold_i & ~flush_i. Ready depends combinationally on valid; valid must not depend on ready. Requester holds all fields stable until accepted.
- Handshake at edge E0 loads the issue register, so mul_* is presented during the following cycle.
- Decode: opcode matches MUL/MULH/MULHSU/MULHU masks -> mul_valid_o=1. Otherwise the op is still accepted with mul_valid_o=0 and err=1, travels the same tag pipe, and returns value 0 with wb_err_o=1.
- Tag pipe: MUL_LATENCY stages of {valid, id, rd, err}, advanced every non-hold edge. Result appears with wb_valid_o=1 sampled at edge E0+MUL_LATENCY+1.
- Throughput is one op per cycle, results in issue order, no back-pressure from writeback.
- hold_i=1: mul_hold_o=1; issue register, tag pipe and rr pointer frozen. wb_valid_o is forced 0, and other wb_* hold their value. The frozen entry presents once after hold drops, never duplicated.
- flush_i=1: at the next edge the issue register and all tag valids clear. mul_valid_o=0 thereafter, and no wb is produced for discarded ops. flush wins over hold and over a simultaneous request (ready low).
- wb_valid_o=0 in a non-hold cycle -> wb_value_o=0, wb_err_o=0.
- busy_o = OR of issue valid and all tag valids.

Decomposition:
- Shared package (riscv_base_defines): INST_MUL/MULH/MULHSU/MULHU match/mask constants (existing), MUL_LATENCY default, requester id encodings.
- Natural sub-module riscv_base_mul_rr_arbiter: 2-way round-robin with last-grant register. Issue register, decode and tag pipe stay in the top.

Test Plan:
1. MUL_LATENCY=2; req0 MUL 5*3 rd=7 accepted at E0 -> at E0+3 wb_valid_o=1, wb_id_o=0, rd=7, value 0x0000000F; busy_o=0 afterwards.
2. Both valid continuously for 4 cycles: req0 MUL -5*3, req1 MULHU 0xFFFFFFFF*2 -> grants 0,1,0,1; wb sequence 0xFFFFFFF1, 0x00000001, 0xFFFFFFF1, 0x00000001 on consecutive cycles with matching ids.
3. Op in flight, hold_i high 2 cycles -> wb_valid_o low during hold, wb delayed exactly 2 cycles, exactly one wb pulse; no grants during hold.
4. Two ops in flight, flush_i one cycle -> no wb for either, busy_o=0 after that edge; req1 MULH -5*3 next cycle -> wb 0xFFFFFFFF at E0+3.
5. req0 opcode 0x00000033 (ADD) -> mul_valid_o stays 0; at E0+3 wb_valid_o=1, wb_err_o=1, value 0.
6. rst_i driven low mid-flight -> all outputs 0 immediately without a clock edge; after release no stale wb, and the first tie grants req0.
